// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the CPU data port and data_memory.
// Optional store-to-load forwarding of exact word matches: define STORE_FWD_EN.
module dmem_store_buffer #(
    parameter int ram_width = 32,
    parameter int ram_add   = 8,
    parameter int depth     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cpu_en_i,
    input  logic                     cpu_we_i,
    input  logic [ram_add-1:0]       cpu_addr_i,
    input  logic [ram_width-1:0]     cpu_din_i,
    input  logic [1:0]               cpu_data_format_i,
    input  logic                     cpu_data_sign_i,
    output logic [ram_width-1:0]     cpu_dout_o,
    output logic                     stall_o,
    output logic                     mem_en_o,
    output logic                     mem_we_o,
    output logic [ram_add-1:0]       mem_addr_o,
    output logic [ram_width-1:0]     mem_din_o,
    output logic [1:0]               mem_data_format_o,
    output logic                     mem_data_sign_o,
    input  logic [ram_width-1:0]     mem_dout_i,
    output logic                     empty_o,
    output logic [$clog2(depth):0]   count_o
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] FMT_WORD = 2'b10;

    typedef struct packed {
        logic [ram_add-1:0]   addr;
        logic [ram_width-1:0] data;
        logic [1:0]           fmt;
    } entry_t;

    typedef enum logic [1:0] {MODE_IDLE, MODE_LOAD, MODE_DRAIN} mode_e;

    entry_t           fifo_q [depth];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    mode_e  mode;
    entry_t head_entry;
    logic   is_load, is_store, full, empty, hazard, fwd_hit, push, pop;

    assign is_load    = cpu_en_i && !cpu_we_i;
    assign is_store   = cpu_en_i && cpu_we_i;
    assign full       = (count_q == CNT_W'(depth));
    assign empty      = (count_q == '0);
    assign head_entry = fifo_q[head_q];

`ifdef STORE_FWD_EN
    logic                 young_exact, any_nonword, fwd_valid_q;
    logic [ram_width-1:0] young_data, fwd_data_q;
`endif

    // Scan from head to tail so the last match seen is the youngest one.
    // NOTE: every always_comb output gets a default before any branch, so no latch can form.
    always_comb begin
        hazard = 1'b0;
`ifdef STORE_FWD_EN
        young_exact = 1'b0;
        any_nonword = 1'b0;
        young_data  = '0;
`endif
        for (int i = 0; i < depth; i++) begin
            if (CNT_W'(i) < count_q &&
                fifo_q[head_q + PTR_W'(i)].addr[ram_add-1:2] == cpu_addr_i[ram_add-1:2]) begin
                hazard = 1'b1;
`ifdef STORE_FWD_EN
                young_exact = (fifo_q[head_q + PTR_W'(i)].addr == cpu_addr_i) &&
                              (fifo_q[head_q + PTR_W'(i)].fmt == FMT_WORD);
                young_data  = fifo_q[head_q + PTR_W'(i)].data;
                if (fifo_q[head_q + PTR_W'(i)].fmt != FMT_WORD) any_nonword = 1'b1;
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    assign fwd_hit = is_load && (cpu_data_format_i == FMT_WORD) && hazard &&
                     young_exact && !any_nonword;
`else
    assign fwd_hit = 1'b0;
`endif

    always_comb begin
        mode    = MODE_IDLE;
        stall_o = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (rst_ni) begin
            if (is_load && !hazard)
                mode = MODE_LOAD;
            else if (!empty && (!cpu_en_i || (is_store && full) || (is_load && hazard)))
                mode = MODE_DRAIN;
            push    = is_store && !full;
            pop     = (mode == MODE_DRAIN);
            stall_o = (is_store && full) || (is_load && hazard && !fwd_hit);
        end
    end

    always_comb begin
        mem_en_o          = 1'b0;
        mem_we_o          = 1'b0;
        mem_addr_o        = '0;
        mem_din_o         = '0;
        mem_data_format_o = '0;
        mem_data_sign_o   = 1'b0;
        case (mode)
            MODE_LOAD: begin
                mem_en_o          = 1'b1;
                mem_addr_o        = cpu_addr_i;
                mem_data_format_o = cpu_data_format_i;
                mem_data_sign_o   = cpu_data_sign_i;
            end
            MODE_DRAIN: begin
                mem_en_o          = 1'b1;
                mem_we_o          = 1'b1;
                mem_addr_o        = head_entry.addr;
                mem_din_o         = head_entry.data;
                mem_data_format_o = head_entry.fmt;
            end
            default: ;
        endcase
    end

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        if (push)     count_d = count_q + 1'b1;
        else if (pop) count_d = count_q - 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array has no reset; count_q alone decides which slots are valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[tail_q] <= '{addr: cpu_addr_i, data: cpu_din_i, fmt: cpu_data_format_i};
    end

`ifdef STORE_FWD_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_hit;
            if (fwd_hit) fwd_data_q <= young_data;
        end
    end

    assign cpu_dout_o = (rst_ni && fwd_valid_q) ? fwd_data_q : mem_dout_i;
`else
    assign cpu_dout_o = mem_dout_i;
`endif

    assign empty_o = !rst_ni || empty;
    assign count_o = rst_ni ? count_q : '0;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer with a 1-cycle-latency memory model.
// Define STORE_FWD_EN for both bench and RTL to exercise store forwarding.
module tb_dmem_store_buffer;

    localparam logic [1:0] FMT_WORD = 2'b10;
    localparam logic [1:0] FMT_HALF = 2'b01;
`ifdef STORE_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cpu_en_i, cpu_we_i, cpu_data_sign_i;
    logic [7:0]  cpu_addr_i;
    logic [31:0] cpu_din_i, cpu_dout_o;
    logic [1:0]  cpu_data_format_i, mem_data_format_o;
    logic        stall_o, mem_en_o, mem_we_o, mem_data_sign_o, empty_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_din_o, mem_dout_i;
    logic [2:0]  count_o;

    dmem_store_buffer #(.ram_width(32), .ram_add(8), .depth(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cpu_en_i(cpu_en_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_din_i(cpu_din_i), .cpu_data_format_i(cpu_data_format_i),
        .cpu_data_sign_i(cpu_data_sign_i), .cpu_dout_o(cpu_dout_o), .stall_o(stall_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_din_o(mem_din_o), .mem_data_format_o(mem_data_format_o),
        .mem_data_sign_o(mem_data_sign_o), .mem_dout_i(mem_dout_i),
        .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: registered read, write on enable + write-enable.
    logic [31:0] mem_m [256] = '{default: 32'h0};
    logic [31:0] ref_m [256] = '{default: 32'h0};
    logic [31:0] mem_rd_q = 32'h0;
    assign mem_dout_i = mem_rd_q;

    always @(posedge clk_i) begin
        if (mem_en_o && mem_we_o)  mem_m[mem_addr_o] <= mem_din_o;
        if (mem_en_o && !mem_we_o) mem_rd_q <= mem_m[mem_addr_o];
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int due; logic [31:0] data; } ld_t;
    wr_t exp_wr[$];
    ld_t ld_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic        last_we;
    logic [7:0]  last_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: memory writes and load data are compared as the DUT produces them.
    always @(negedge clk_i) begin
        wr_t w;
        ld_t l;
        if (rst_ni) begin
            if (mem_en_o && mem_we_o) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected_addr", 32'(mem_addr_o), 32'hFFFF_FFFF);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_addr_o), 32'(w.addr));
                    check("wr_data", mem_din_o, w.data);
                    check("wr_sign", 32'(mem_data_sign_o), 32'h0);
                end
            end
            if (ld_q.size() > 0 && ld_q[0].due == cyc) begin
                l = ld_q.pop_front();
                check("ld_data", cpu_dout_o, l.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_store(input logic [7:0] a, input logic [31:0] d, output int stalls);
        bit ok = 1'b0;
        stalls = 0;
        cpu_en_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = a; cpu_din_i = d;
        cpu_data_format_i = FMT_WORD; cpu_data_sign_i = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (!stall_o) begin ok = 1'b1; break; end
            stalls++;
            tick();
        end
        if (ok) begin
            exp_wr.push_back('{addr: a, data: d});
            ref_m[a] = d;
        end else begin
            check("st_timeout", 32'h0, 32'h1);
        end
        tick();
        cpu_en_i = 1'b0; cpu_we_i = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [1:0] fmt, output int stalls);
        bit ok = 1'b0;
        stalls = 0;
        cpu_en_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = a; cpu_din_i = 32'h0;
        cpu_data_format_i = fmt; cpu_data_sign_i = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (!stall_o) begin ok = 1'b1; break; end
            stalls++;
            tick();
        end
        if (ok) begin
            last_we   = mem_we_o;
            last_addr = mem_addr_o;
`ifndef STORE_FWD_EN
            check("ld_port_we", 32'(mem_we_o), 32'h0);
            check("ld_port_addr", 32'(mem_addr_o), 32'(a));
            check("ld_port_fmt", 32'(mem_data_format_o), 32'(fmt));
            check("ld_port_sign", 32'(mem_data_sign_o), 32'h1);
`endif
            ld_q.push_back('{due: cyc + 1, data: ref_m[a]});
        end else begin
            check("ld_timeout", 32'h0, 32'h1);
        end
        tick();
        cpu_en_i = 1'b0;
    endtask

    task automatic drain_all();
        cpu_en_i = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (empty_o) break;
            tick();
        end
        check("drain_empty", 32'(empty_o), 32'h1);
        tick();
    endtask

    initial begin
        int st;
        logic [7:0] a;
        rst_ni = 1'b0;
        cpu_en_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 8'h08; cpu_din_i = 32'hAA;
        cpu_data_format_i = FMT_WORD; cpu_data_sign_i = 1'b0;

        // Reset held for two edges with a store request active.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check("rst_empty", 32'(empty_o), 32'h1);
            check("rst_count", 32'(count_o), 32'h0);
            check("rst_mem_en", 32'(mem_en_o), 32'h0);
            check("rst_stall", 32'(stall_o), 32'h0);
            @(posedge clk_i);
        end
        #1;
        rst_ni = 1'b1;
        cpu_en_i = 1'b0;

        // Full FIFO: four stores accepted, the fifth stalls one cycle while entry 1 drains.
        for (int i = 0; i < 5; i++) begin
            do_store(8'(i * 4), 32'(i + 1), st);
            check("full_stalls", 32'(st), (i < 4) ? 32'h0 : 32'h1);
            if (i >= 3) check("full_count", 32'(count_o), 32'h4);
        end
        drain_all();

        // Hazard on the youngest entry (k=0), word load of the same address.
        do_store(8'h10, 32'hDEADBEEF, st);
        do_load(8'h10, FMT_WORD, st);
        check("haz_stalls", 32'(st), (FWD != 0) ? 32'h0 : 32'h1);
        drain_all();

        // Forwarding scenario: stall-free in the forwarding build, drain in the load cycle.
        do_store(8'h20, 32'h12345678, st);
        do_load(8'h20, FMT_WORD, st);
        check("fwd_stalls", 32'(st), (FWD != 0) ? 32'h0 : 32'h1);
        check("fwd_we", 32'(last_we), (FWD != 0) ? 32'h1 : 32'h0);
        check("fwd_addr", 32'(last_addr), 32'h20);
        drain_all();

        // Hazard at k=2 via a different byte of the same word: stalls three cycles.
        do_store(8'h50, 32'h5050, st);
        do_store(8'h54, 32'h5454, st);
        do_store(8'h58, 32'h5858, st);
        do_load(8'h5A, FMT_HALF, st);
        check("haz_k2_stalls", 32'(st), 32'h3);
        // Non-matching load passes straight through while the FIFO is occupied.
        do_store(8'h70, 32'h7070, st);
        do_load(8'h74, FMT_WORD, st);
        check("nohaz_stalls", 32'(st), 32'h0);
        drain_all();

        // Idle drain: three pulses on consecutive cycles, then idle.
        do_store(8'h30, 32'hA, st);
        do_store(8'h34, 32'hB, st);
        do_store(8'h38, 32'hC, st);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("idle_we", 32'(mem_we_o), (i < 3) ? 32'h1 : 32'h0);
            if (i == 3) begin
                check("idle_empty", 32'(empty_o), 32'h1);
                check("idle_mem_en", 32'(mem_en_o), 32'h0);
            end
            tick();
        end

        // Reset mid-operation discards pending entries.
        do_store(8'h60, 32'h111, st);
        do_store(8'h64, 32'h222, st);
        rst_ni = 1'b0;
        exp_wr.delete();
        @(negedge clk_i);
        check("rstmid_mem_en", 32'(mem_en_o), 32'h0);
        check("rstmid_count_lo", 32'(count_o), 32'h0);
        tick();
        rst_ni = 1'b1;
        ref_m = mem_m;
        check("rstmid_count", 32'(count_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("rstmid_no_we", 32'(mem_we_o), 32'h0);
            tick();
        end
        do_load(8'h60, FMT_WORD, st);
        check("rstmid_ld_stalls", 32'(st), 32'h0);

        // Random mix of stores, loads and idle cycles over four words.
        for (int i = 0; i < 60; i++) begin
            a = 8'h40 + 8'($urandom_range(0, 3) * 4);
            case ($urandom_range(0, 9))
                0, 1, 2, 3:    do_store(a, $urandom, st);
                4, 5, 6, 7:    do_load(a, FMT_WORD, st);
                default: begin cpu_en_i = 1'b0; tick(); end
            endcase
        end
        drain_all();
        tick();
        tick();
        check("end_wr_queue", 32'(exp_wr.size()), 32'h0);
        check("end_ld_queue", 32'(ld_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
